// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;
    localparam int DIV_WIDTH = 8;
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/eight_bit_sequential_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface eight_bit_sequential_divider_if;
    import div_pkg::*;

    logic                 start;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/eight_bit_lookahead_adder.sv
// 8-bit carry-lookahead adder: two 4-bit lookahead groups joined by a group-level carry.
module eight_bit_lookahead_adder (
    output logic [7:0] sum,
    output logic       cout,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin
);
    logic [7:0] gen;
    logic [7:0] prop;
    logic [1:0] grp_g;
    logic [1:0] grp_p;
    logic [1:0] nib_cin;

    assign gen  = a & b;
    assign prop = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nibble
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g    = gen[4*gi +: 4];
            assign p    = prop[4*gi +: 4];
            assign c[0] = nib_cin[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);

            assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                             | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p[gi] = &p;
            assign sum[4*gi +: 4] = p ^ c;
        end
    endgenerate

    assign nib_cin[0] = cin;
    assign nib_cin[1] = grp_g[0] | (grp_p[0] & cin);
    assign cout       = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
endmodule

// File: rtl/eight_bit_lookahead_subtractor.sv
// a - b as a + ~b + 1 through the lookahead adder; carry-out high means no borrow.
module eight_bit_lookahead_subtractor (
    output logic [7:0] diff,
    output logic       no_borrow,
    input  logic [7:0] a,
    input  logic [7:0] b
);
    eight_bit_lookahead_adder u_add (
        .sum  (diff),
        .cout (no_borrow),
        .a    (a),
        .b    (~b),
        .cin  (1'b1)
    );
endmodule

// File: rtl/eight_bit_sequential_divider.sv
// Unsigned 8-bit restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor straight to DONE.
module eight_bit_sequential_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    eight_bit_sequential_divider_if.slave    bus
);
    div_state_t            state_reg, state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0]      q_reg, q_next;
    logic [WIDTH-1:0]      rem_reg, rem_next;
    logic [WIDTH-1:0]      div_reg, div_next;
    logic [WIDTH-1:0]      quot_out_reg, quot_out_next;
    logic [WIDTH-1:0]      rem_out_reg, rem_out_next;
    logic                  dbz_reg, dbz_next;

    logic [WIDTH-1:0]      shifted_low;
    logic [WIDTH-1:0]      trial_diff;
    logic [WIDTH-1:0]      rem_step;
    logic [WIDTH-1:0]      q_step;
    logic                  no_borrow;
    logic                  take_diff;
    logic                  zero_detect;

    // The 9-bit shifted remainder is {rem_reg[MSB], shifted_low}; a set MSB always wins the trial.
    assign shifted_low = {rem_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign take_diff   = rem_reg[WIDTH-1] | no_borrow;
    assign rem_step    = take_diff ? trial_diff : shifted_low;
    assign q_step      = {q_reg[WIDTH-2:0], take_diff};

    eight_bit_lookahead_subtractor u_sub (
        .diff      (trial_diff),
        .no_borrow (no_borrow),
        .a         (shifted_low),
        .b         (div_reg)
    );

`ifdef DIV_ZERO_CHECK_EN
    assign zero_detect = (bus.divisor == '0);
`else
    assign zero_detect = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            q_reg        <= '0;
            rem_reg      <= '0;
            div_reg      <= '0;
            quot_out_reg <= '0;
            rem_out_reg  <= '0;
            dbz_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            q_reg        <= q_next;
            rem_reg      <= rem_next;
            div_reg      <= div_next;
            quot_out_reg <= quot_out_next;
            rem_out_reg  <= rem_out_next;
            dbz_reg      <= dbz_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        q_next        = q_reg;
        rem_next      = rem_reg;
        div_next      = div_reg;
        quot_out_next = quot_out_reg;
        rem_out_next  = rem_out_reg;
        dbz_next      = dbz_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (state_reg == DONE) state_next = IDLE;
                if (bus.start) begin
                    q_next   = bus.dividend;
                    div_next = bus.divisor;
                    rem_next = '0;
                    cnt_next = CNT_WIDTH'(WIDTH);
                    dbz_next = 1'b0;
                    if (zero_detect) begin
                        state_next    = DONE;
                        quot_out_next = '1;
                        rem_out_next  = bus.dividend;
                        dbz_next      = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                q_next   = q_step;
                rem_next = rem_step;
                cnt_next = cnt_reg - CNT_WIDTH'(1);
                // Results land in the output registers on the final iteration edge.
                if (cnt_reg == CNT_WIDTH'(1)) begin
                    state_next    = DONE;
                    quot_out_next = q_step;
                    rem_out_next  = rem_step;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy        = (state_reg == RUN);
    assign bus.done        = (state_reg == DONE);
    assign bus.quotient    = quot_out_reg;
    assign bus.remainder   = rem_out_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_eight_bit_sequential_divider.sv
// Scoreboard bench for the sequential divider: expected results queued at start, checked at done.
module tb_eight_bit_sequential_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eight_bit_sequential_divider_if dif();

    eight_bit_sequential_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    typedef struct {
        logic [7:0] quot;
        logic [7:0] rem;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive a start at the current negedge and queue the model's answer.
    task automatic push_op(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.quot = (b == 8'd0) ? 8'hFF : a / b;
        e.rem  = (b == 8'd0) ? a : a % b;
`ifdef DIV_ZERO_CHECK_EN
        e.dbz = (b == 8'd0);
        e.lat = (b == 8'd0) ? 1 : 9;
`else
        e.dbz = 1'b0;
        e.lat = 9;
`endif
        sb.push_back(e);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
    endtask

    // Step until done (bounded); lat counts edges from the start edge.
    task automatic wait_done(input int limit, output int lat, output int busy_cycles, output bit overlap);
        busy_cycles = 0;
        overlap     = 1'b0;
        tick();
        dif.start = 1'b0;
        lat = 1;
        while (dif.done !== 1'b1 && lat < limit) begin
            if (dif.busy === 1'b1) busy_cycles++;
            if (dif.busy === 1'b1 && dif.done === 1'b1) overlap = 1'b1;
            tick();
            lat++;
        end
        if (dif.busy === 1'b1 && dif.done === 1'b1) overlap = 1'b1;
    endtask

    task automatic test_reset();
        dif.start = 1'b0; dif.dividend = 8'd0; dif.divisor = 8'd0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== 19'd0)
            begin errors++; $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero); end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({dif.busy, dif.done} !== 2'b00)
            begin errors++; $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", dif.busy, dif.done); end
    endtask

    task automatic test_basic();
        exp_t e; int lat; int bc; bit ov;
        push_op(8'd100, 8'd7);
        wait_done(20, lat, bc, ov);
        e = sb.pop_front();
        checks++;
        if (dif.done !== 1'b1 || lat != e.lat)
            begin errors++; $display("FAIL basic_latency: got done=%b at %0d cycles, want done at %0d", dif.done, lat, e.lat); end
        checks++;
        if (bc != 8 || ov)
            begin errors++; $display("FAIL basic_busy: got %0d busy cycles overlap=%b, want 8 and 0", bc, ov); end
        checks++;
        if (dif.quotient !== e.quot || dif.remainder !== e.rem || dif.div_by_zero !== e.dbz)
            begin errors++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                dif.quotient, dif.remainder, dif.div_by_zero, e.quot, e.rem, e.dbz); end
        tick();
        checks++;
        if (dif.done !== 1'b0 || dif.busy !== 1'b0 || dif.quotient !== 8'd14 || dif.remainder !== 8'd2)
            begin errors++; $display("FAIL basic_after_done: got done=%b busy=%b q=%0d r=%0d, want 0 0 14 2",
                dif.done, dif.busy, dif.quotient, dif.remainder); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] op_a [3];
        logic [7:0] op_b [3];
        exp_t e; int lat; int bc; bit ov;
        op_a[0] = 8'd255; op_b[0] = 8'd1;
        op_a[1] = 8'd5;   op_b[1] = 8'd9;
        op_a[2] = 8'd200; op_b[2] = 8'd200;
        push_op(op_a[0], op_b[0]);
        for (int i = 0; i < 3; i++) begin
            wait_done(20, lat, bc, ov);
            e = sb.pop_front();
            checks++;
            if (dif.done !== 1'b1 || lat != 9 || ov)
                begin errors++; $display("FAIL b2b_interval[%0d]: got done=%b after %0d cycles overlap=%b, want done after 9, no overlap",
                    i, dif.done, lat, ov); end
            checks++;
            if (dif.quotient !== e.quot || dif.remainder !== e.rem)
                begin errors++; $display("FAIL b2b_result[%0d]: got q=%0d r=%0d, want q=%0d r=%0d",
                    i, dif.quotient, dif.remainder, e.quot, e.rem); end
            if (i < 2) push_op(op_a[i+1], op_b[i+1]);
        end
        tick();
        checks++;
        if (dif.done !== 1'b0 || dif.busy !== 1'b0)
            begin errors++; $display("FAIL b2b_end: got done=%b busy=%b, want 0 0", dif.done, dif.busy); end
    endtask

    task automatic test_div_zero();
        exp_t e; int lat; int bc; bit ov;
        push_op(8'd42, 8'd0);
        wait_done(20, lat, bc, ov);
        e = sb.pop_front();
        checks++;
        if (dif.done !== 1'b1 || lat != e.lat || bc != e.lat - 1)
            begin errors++; $display("FAIL divzero_latency: got done=%b lat=%0d busy=%0d, want done lat=%0d busy=%0d",
                dif.done, lat, bc, e.lat, e.lat - 1); end
        checks++;
        if (dif.quotient !== e.quot || dif.remainder !== e.rem || dif.div_by_zero !== e.dbz)
            begin errors++; $display("FAIL divzero_result: got q=%h r=%0d dbz=%b, want q=%h r=%0d dbz=%b",
                dif.quotient, dif.remainder, dif.div_by_zero, e.quot, e.rem, e.dbz); end
        repeat (2) tick();
        checks++;
        if (dif.div_by_zero !== e.dbz || dif.remainder !== 8'd42)
            begin errors++; $display("FAIL divzero_hold: got dbz=%b r=%0d, want dbz=%b r=42", dif.div_by_zero, dif.remainder, e.dbz); end
    endtask

    task automatic test_ignore_start();
        exp_t e; int edge_n; bit busy_drop; bit extra_done;
        push_op(8'd77, 8'd3);
        tick();
        dif.start = 1'b0;
        repeat (3) tick();
        dif.start = 1'b1; dif.dividend = 8'd10; dif.divisor = 8'd2;
        tick();
        dif.start = 1'b0; dif.dividend = 8'd0; dif.divisor = 8'd0;
        edge_n = 4;
        busy_drop = 1'b0;
        while (dif.done !== 1'b1 && edge_n < 20) begin
            if (dif.busy !== 1'b1) busy_drop = 1'b1;
            tick();
            edge_n++;
        end
        e = sb.pop_front();
        checks++;
        if (dif.done !== 1'b1 || edge_n != 8 || busy_drop)
            begin errors++; $display("FAIL ignore_timing: got done=%b after edge %0d busy_drop=%b, want done after edge 8",
                dif.done, edge_n, busy_drop); end
        checks++;
        if (dif.quotient !== e.quot || dif.remainder !== e.rem)
            begin errors++; $display("FAIL ignore_result: got q=%0d r=%0d, want q=%0d r=%0d", dif.quotient, dif.remainder, e.quot, e.rem); end
        extra_done = 1'b0;
        repeat (12) begin
            tick();
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) extra_done = 1'b1;
        end
        checks++;
        if (extra_done || dif.quotient !== 8'd25 || dif.remainder !== 8'd2)
            begin errors++; $display("FAIL ignore_hold: got stray activity=%b q=%0d r=%0d, want 0 25 2",
                extra_done, dif.quotient, dif.remainder); end
    endtask

    task automatic test_async_reset();
        exp_t e; int lat; int bc; bit ov; bit stray;
        dif.start = 1'b1; dif.dividend = 8'd200; dif.divisor = 8'd3;
        tick();
        dif.start = 1'b0;
        tick();
        checks++;
        if (dif.busy !== 1'b1 || dif.quotient !== 8'd25 || dif.remainder !== 8'd2)
            begin errors++; $display("FAIL run_hold: got busy=%b q=%0d r=%0d, want 1 25 2", dif.busy, dif.quotient, dif.remainder); end
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero} !== 19'd0)
            begin errors++; $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero); end
        repeat (2) tick();
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            tick();
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray)
            begin errors++; $display("FAIL reset_no_done: got busy/done activity after abort, want none"); end
        push_op(8'd9, 8'd4);
        wait_done(20, lat, bc, ov);
        e = sb.pop_front();
        checks++;
        if (dif.done !== 1'b1 || lat != 9 || dif.quotient !== e.quot || dif.remainder !== e.rem)
            begin errors++; $display("FAIL post_reset_op: got done=%b lat=%0d q=%0d r=%0d, want done lat=9 q=%0d r=%0d",
                dif.done, lat, dif.quotient, dif.remainder, e.quot, e.rem); end
        tick();
    endtask

    task automatic test_sweep();
        logic [7:0] edge_a [6];
        logic [7:0] edge_b [6];
        logic [7:0] a; logic [7:0] b;
        exp_t e; int lat; int bc; bit ov;
        edge_a[0] = 8'd0;   edge_b[0] = 8'd1;
        edge_a[1] = 8'd255; edge_b[1] = 8'd255;
        edge_a[2] = 8'd1;   edge_b[2] = 8'd255;
        edge_a[3] = 8'd128; edge_b[3] = 8'd1;
        edge_a[4] = 8'd255; edge_b[4] = 8'd128;
        edge_a[5] = 8'd254; edge_b[5] = 8'd255;
        for (int i = 0; i < 1506; i++) begin
            if (i < 6) begin
                a = edge_a[i]; b = edge_b[i];
            end else begin
                a = 8'($urandom_range(255, 0));
                b = 8'($urandom_range(255, 1));
            end
            push_op(a, b);
            wait_done(20, lat, bc, ov);
            e = sb.pop_front();
            checks++;
            if (dif.done !== 1'b1 || lat != 9 || ov || dif.quotient !== e.quot || dif.remainder !== e.rem
                || dif.div_by_zero !== 1'b0)
                begin errors++; $display("FAIL sweep %0d/%0d: got done=%b lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=%0d r=%0d dbz=0",
                    a, b, dif.done, lat, dif.quotient, dif.remainder, dif.div_by_zero, e.quot, e.rem); end
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();
        checks++;
        if (sb.size() != 0)
            begin errors++; $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_async_reset();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
